// File: rtl/base_areg_slice_pkg.sv
// Shared helpers for the base register slice.
// Trace label encodings and the ready equation.
package base_areg_slice_pkg;

  typedef enum logic [2:0] {
    LBL_GEN  = 3'b000,
    LBL_SBUF = 3'b001,
    LBL_ALU  = 3'b010,
    LBL_MEM  = 3'b011,
    LBL_WB   = 3'b100,
    LBL_DBG  = 3'b111
  } lbl_e;

  // Upstream may push when the slot is empty
  // or the held entry leaves on this edge.
  function automatic logic slice_ready(
    input logic full,
    input logic take
  );
    return ~full | take;
  endfunction

endpackage

// File: rtl/base_areg_slice_vlat_en.sv
// Generic enabled register with a synchronous
// reset value; usable as a state flop or counter.
module base_vlat_en
  import base_areg_slice_pkg::*;
#(
  parameter int unsigned       width = 1,
  parameter logic [width-1:0]  rstv  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] din,
  output logic [width-1:0] q
);

  // Reset wins; otherwise load on enable, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rstv;
    end else if (enable) begin
      q <= din;
    end
  end

endmodule

// File: rtl/base_areg_slice.sv
// Single-entry valid/ready register slice:
// registered outputs, one cycle latency, full rate.
module base_areg_slice
  import base_areg_slice_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter logic [2:0]  lbl   = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d
);

  logic w_i_act;
  logic w_o_act;
  logic w_v_en;
  logic w_unused_lbl;

  // The label only tags the instance in traces.
  assign w_unused_lbl = (lbl_e'(lbl) == LBL_GEN);

  // Ready never looks at i_v; its only
  // combinational input is o_r.
  assign i_r     = slice_ready(o_v, o_r);
  assign w_i_act = i_v & i_r;
  assign w_o_act = o_v & o_r;

  // Valid flips on either handshake; a
  // simultaneous push and pop keeps it set.
  assign w_v_en  = w_i_act | w_o_act;

  base_vlat_en #(
    .width (1),
    .rstv  (1'b0)
  ) u_vreg (
    .clk    (clk),
    .reset  (reset),
    .enable (w_v_en),
    .din    (w_i_act),
    .q      (o_v)
  );

  base_vlat_en #(
    .width (width),
    .rstv  ('0)
  ) u_dreg (
    .clk    (clk),
    .reset  (reset),
    .enable (w_i_act),
    .din    (i_d),
    .q      (o_d)
  );

endmodule

// File: tb/tb_base_areg_slice.sv
// Directed bench for the register slice
// and the stand-alone enabled register.
module tb_base_areg_slice;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         i_v;
  logic         i_r;
  logic [W-1:0] i_d;
  logic         o_v;
  logic         o_r;
  logic [W-1:0] o_d;

  logic         c_rst;
  logic         c_en;
  logic [3:0]   c_q;
  logic [3:0]   c_din;

  int n_pass;
  int n_total;

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] id;
    logic         orr;
    logic         chk_ir;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tv [18];

  base_areg_slice #(
    .width (W),
    .lbl   (3'b001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (i_d),
    .o_v   (o_v),
    .o_r   (o_r),
    .o_d   (o_d)
  );

  assign c_din = c_q + 4'd1;

  base_vlat_en #(
    .width (4),
    .rstv  (4'd3)
  ) u_cnt (
    .clk    (clk),
    .reset  (c_rst),
    .enable (c_en),
    .din    (c_din),
    .q      (c_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic         rst,
    input logic         iv,
    input logic [W-1:0] id,
    input logic         orr,
    input logic         chk_ir,
    input logic         e_ir,
    input logic         e_ov,
    input logic [W-1:0] e_od
  );
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.orr = orr;
    v.chk_ir = chk_ir; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_od = e_od;
    return v;
  endfunction

  logic [3:0] exp_q;

  initial begin
    n_pass  = 0;
    n_total = 0;

    // reset hold with traffic, release
    tv[0]  = mk(1, 1, 8'hAA, 0, 1, 1, 0, 8'h00);
    tv[1]  = mk(1, 1, 8'hAA, 0, 1, 1, 0, 8'h00);
    tv[2]  = mk(1, 1, 8'hAA, 0, 1, 1, 0, 8'h00);
    tv[3]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h00);
    // single transfer
    tv[4]  = mk(0, 1, 8'h05, 1, 1, 1, 1, 8'h05);
    tv[5]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h05);
    // back-pressure
    tv[6]  = mk(0, 1, 8'h11, 0, 1, 1, 1, 8'h11);
    tv[7]  = mk(0, 1, 8'h22, 0, 1, 0, 1, 8'h11);
    tv[8]  = mk(0, 1, 8'h22, 0, 1, 0, 1, 8'h11);
    tv[9]  = mk(0, 1, 8'h22, 0, 1, 0, 1, 8'h11);
    tv[10] = mk(0, 1, 8'h22, 0, 1, 0, 1, 8'h11);
    tv[11] = mk(0, 1, 8'h22, 1, 1, 1, 1, 8'h22);
    tv[12] = mk(0, 0, 8'h00, 0, 1, 0, 1, 8'h22);
    tv[13] = mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h22);
    // empty slice is ready with o_r low
    tv[14] = mk(0, 0, 8'h00, 0, 1, 1, 0, 8'h22);
    // reset while full and stalled
    tv[15] = mk(0, 1, 8'h33, 0, 1, 1, 1, 8'h33);
    tv[16] = mk(1, 1, 8'h44, 0, 0, 0, 0, 8'h00);
    tv[17] = mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h00);

    reset = 1'b1;
    i_v   = 1'b0;
    i_d   = '0;
    o_r   = 1'b0;
    c_rst = 1'b1;
    c_en  = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      reset = tv[i].rst;
      i_v   = tv[i].iv;
      i_d   = tv[i].id;
      o_r   = tv[i].orr;
      #1;
      if (tv[i].chk_ir)
        chk($sformatf("v%0d i_r", i), 32'(i_r), 32'(tv[i].e_ir));
      tick();
      chk($sformatf("v%0d o_v", i), 32'(o_v), 32'(tv[i].e_ov));
      chk($sformatf("v%0d o_d", i), 32'(o_d), 32'(tv[i].e_od));
    end

    // streaming 1..10 at full rate
    reset = 1'b0;
    o_r   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      i_v = 1'b1;
      i_d = W'(k);
      #1;
      chk($sformatf("st%0d i_r", k), 32'(i_r), 32'd1);
      tick();
      chk($sformatf("st%0d o_v", k), 32'(o_v), 32'd1);
      chk($sformatf("st%0d o_d", k), 32'(o_d), 32'(k));
    end
    i_v = 1'b0;
    i_d = '0;
    tick();
    chk("st_end o_v", 32'(o_v), 32'd0);
    chk("st_end o_d", 32'(o_d), 32'd10);

    // counter from rstv with toggling enable
    c_rst = 1'b1;
    c_en  = 1'b1;
    tick();
    chk("cnt rst", 32'(c_q), 32'd3);
    c_rst = 1'b0;
    exp_q = 4'd3;
    for (int n = 0; n < 30; n++) begin
      c_en = n[0];
      tick();
      if (c_en) exp_q = exp_q + 4'd1;
      chk($sformatf("cnt%0d", n), 32'(c_q), 32'(exp_q));
    end
    c_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (c_q == 4'd15) break;
      tick();
    end
    tick();
    chk("cnt wrap", 32'(c_q), 32'd0);
    c_rst = 1'b1;
    tick();
    chk("cnt rst2", 32'(c_q), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
